udp_header_parser: RTL and testbench
====================================

Name: udp_header_parser

Overview:
- Sits directly downstream of the ingress MAC filter.
- Consumes accepted Ethernet frames on a 64-bit AXI-Stream. Validates the Ethernet/IPv4/UDP headers, strips the 42 header bytes and emits the UDP payload realigned to lane 0.
- Presents the decoded header fields and the ingress timestamp as sideband to the downstream feed decoder.
- Non-UDP, fragmented and runt frames are dropped and counted.

Parameters:
- DATA_WIDTH, 64, stream width in bits; only 64 is supported.
- KEEP_WIDTH, 8, byte-enable width, DATA_WIDTH/8.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- s_axis_tdata  in  64  frame data. Frame byte n is on beat n/8, bits [8*(n%8)+7 : 8*(n%8)].
- s_axis_tkeep  in  8  contiguous from lane 0; must be 0xFF on non-last beats.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  48  ingress timestamp; sampled on beat 0 only.
- m_axis_tdata  out  64  payload; payload byte k is at lane k%8.
- m_axis_tkeep  out  8  contiguous from lane 0.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last payload beat.
- m_axis_tuser  out  48  frame timestamp, constant for the whole frame.
- m_src_ip, m_dst_ip  out  32 each  IPv4 addresses, network order (byte 26 / byte 30 in bits [31:24]).
- m_src_port, m_dst_port, m_udp_len  out  16 each  UDP fields, network order.
- udp_count, runt_drop_count, proto_drop_count  out  32 each  wrapping statistics counters.

Behaviour:
- Reset: all outputs 0, state HDR, beat counter 0, counters 0. Reset asserted mid-frame abandons that frame. The next accepted beat is parsed as beat 0.
- States:
  - HDR: beats 0..5; s_axis_tready=1; header bytes captured; no output.
  - PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - FLUSH: s_axis_tready=0; emits residual bytes.
  - DROP: s_axis_tready=1; discards through tlast, then returns to HDR.
- Header checks, all resolved by the end of beat 2. Any failure increments proto_drop_count once and goes to DROP, or straight to HDR if that beat is tlast.
  - Ethertype {byte12,byte13}=0x0800.
  - Byte14=0x45 (IPv4, IHL 5).
  - Byte23 (protocol)=17.
  - Flags/offset {byte20,byte21} & 0x3FFF = 0, i.e. MF clear and offset 0.
- Runt: tlast on beats 0..4, or tlast on beat 5 with tkeep count ≤2 (zero payload bytes).
  - Increments runt_drop_count, returns to HDR, no output.
  - A proto failure takes precedence over runt when both apply.
- Beat 5 processing:
  - Lanes 0-1 are the UDP checksum, ignored.
  - Lanes 2-7 are loaded into a 6-byte hold register.
  - Header sideband outputs and m_axis_tuser update when beat 5 is accepted and stay stable until the next frame's beat 5.
  - udp_count increments at beat 5 for every non-dropped frame.
- Beat 5 is tlast with keep count c>2: enter FLUSH and emit one beat with c-2 bytes in lanes 0..c-3, tlast=1.
- PAYLOAD, per accepted input beat with keep count c. The output register loads {in lanes 0-1 → out lanes 6-7, hold → out lanes 0-5}, and hold is reloaded with input lanes 2-7.
  - Non-last beat: emit 8 bytes, tkeep 0xFF.
  - tlast with c≤2: emit 6+c bytes, tlast=1, go to HDR.
  - tlast with c>2: emit 8 bytes with tlast=0, then FLUSH emits c-2 bytes with tlast=1.
- Output is fully registered. Latency is one cycle from accepting an input beat to m_axis_tvalid.
- Output data, keep and last hold stable while tvalid=1 and tready=0.
- FLUSH exits to HDR on the output handshake. The next frame's beat 0 may be accepted in that same cycle.
- Counters wrap at 2^32.

Test Plan:
- 60-byte valid UDP frame (beats 0-6 full, beat 7 tkeep 0x0F, tlast), ready=1 → 3 output beats with tkeep 0xFF, 0xFF, 0x03, tlast on the third; payload bytes 42..59 in order; udp_count=1.
- 64-byte frame (8 full beats) → 3 output beats with tkeep 0xFF, 0xFF, 0x3F. 43-byte frame (beat 5 tkeep 0x07) → 1 beat, tkeep 0x01, tlast. 42-byte frame → no output, runt_drop_count=1.
- Ethertype 0x86DD, protocol 6, and MF=1 frames, back-to-back → no output; proto_drop_count=3; s_axis_tready stays 1 throughout.
- 100-byte UDP frame with m_axis_tready toggling 1,0,0,1 → no payload bytes lost or duplicated; outputs stable during stalls; s_axis_tready low whenever the output is held.
- s_axis_tuser=0x00000000ABCD on beat 0 and a different value on later beats → m_axis_tuser=0x00000000ABCD on every output beat. m_src_port/m_dst_port equal bytes 34-35/36-37 in network order.
- rst pulsed during beat 7 of a frame → all outputs 0 immediately. A following clean 60-byte frame parses correctly with udp_count=1.

Source files
------------

// File: rtl/udp_header_parser.sv
// -----------------------------------------------------------------------------
// udp_header_parser
//
// Purpose: takes accepted Ethernet frames on a 64-bit AXI-Stream, validates the
// Ethernet/IPv4/UDP headers, strips the 42 header bytes and emits the UDP
// payload realigned to lane 0. Decoded header fields and the beat-0 ingress
// timestamp are presented as sideband. Non-UDP, fragmented and runt frames are
// dropped and counted.
//
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   s_axis_t{data,keep,valid,ready,last,user}
//                                 ingress frame stream; tuser = timestamp (beat 0)
//   m_axis_t{data,keep,valid,ready,last,user}
//                                 payload stream; tuser = frame timestamp
//   m_src_ip, m_dst_ip            IPv4 addresses, network order
//   m_src_port, m_dst_port,
//   m_udp_len                     UDP header fields, network order
//   udp_count, runt_drop_count,
//   proto_drop_count              wrapping statistics counters
// -----------------------------------------------------------------------------
module udp_header_parser #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [47:0]           s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [47:0]           m_axis_tuser,
  output logic [31:0]           m_src_ip,
  output logic [31:0]           m_dst_ip,
  output logic [15:0]           m_src_port,
  output logic [15:0]           m_dst_port,
  output logic [15:0]           m_udp_len,
  output logic [31:0]           udp_count,
  output logic [31:0]           runt_drop_count,
  output logic [31:0]           proto_drop_count
);

  typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_FLUSH, ST_DROP} state_e;

  function automatic logic [3:0] keep_count(input logic [KEEP_WIDTH-1:0] k);
    keep_count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) keep_count = keep_count + 4'(k[i]);
  endfunction

  // Contiguous low-lane byte mask with n (0..8) lanes set.
  function automatic logic [7:0] lo_mask(input logic [3:0] n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction

  // Two consecutive lanes starting at lane n, first lane in the upper byte.
  function automatic logic [15:0] be16(input logic [63:0] d, input int n);
    return {d[8*n +: 8], d[8*(n+1) +: 8]};
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [47:0]   hold_q, hold_d;
  logic [2:0]    res_q, res_d;
  // Header fields captured on beats 0..4; published only at beat 5.
  logic [47:0]   ts_q, ts_d;
  logic [31:0]   sip_q, sip_d, dip_q, dip_d;
  logic [15:0]   sport_q, sport_d, dport_q, dport_d, ulen_q, ulen_d;
  logic [63:0]   tdata_q, tdata_d;
  logic [7:0]    tkeep_q, tkeep_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [47:0]   tuser_q, tuser_d;
  logic [31:0]   src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0]   src_port_q, src_port_d, dst_port_q, dst_port_d, udp_len_q, udp_len_d;
  logic [31:0]   udp_cnt_q, udp_cnt_d, runt_cnt_q, runt_cnt_d, proto_cnt_q, proto_cnt_d;

  logic          ready_c, out_free, drop_proto, drop_runt, hdr1_ok, hdr2_ok;
  logic [3:0]    in_c;

  assign in_c     = keep_count(s_axis_tkeep);
  assign out_free = !tvalid_q || m_axis_tready;
  // Ethertype 0x0800 and version/IHL 0x45 live in beat 1; flags/offset and
  // protocol live in beat 2.
  assign hdr1_ok  = (be16(s_axis_tdata, 4) == 16'h0800) && (s_axis_tdata[55:48] == 8'h45);
  assign hdr2_ok  = ((be16(s_axis_tdata, 4) & 16'h3FFF) == 16'h0000) &&
                    (s_axis_tdata[63:56] == 8'd17);

  // NOTE: every variable gets its default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;     beat_d      = beat_q;      hold_d     = hold_q;
    res_d       = res_q;       ts_d        = ts_q;        sip_d      = sip_q;
    dip_d       = dip_q;       sport_d     = sport_q;     dport_d    = dport_q;
    ulen_d      = ulen_q;      tdata_d     = tdata_q;     tkeep_d    = tkeep_q;
    tlast_d     = tlast_q;     tuser_d     = tuser_q;     src_ip_d   = src_ip_q;
    dst_ip_d    = dst_ip_q;    src_port_d  = src_port_q;  dst_port_d = dst_port_q;
    udp_len_d   = udp_len_q;   udp_cnt_d   = udp_cnt_q;   runt_cnt_d = runt_cnt_q;
    proto_cnt_d = proto_cnt_q;
    tvalid_d    = tvalid_q && !m_axis_tready;
    ready_c     = 1'b0;
    drop_proto  = 1'b0;
    drop_runt   = 1'b0;

    unique case (state_q)
      ST_HDR: begin
        ready_c = 1'b1;
        if (s_axis_tvalid) begin
          beat_d = beat_q + 3'd1;
          unique case (beat_q)
            3'd0: begin
              ts_d      = s_axis_tuser;
              drop_runt = s_axis_tlast;
            end
            3'd1: begin
              drop_proto = !hdr1_ok;
              drop_runt  = s_axis_tlast;
            end
            3'd2: begin
              drop_proto = !hdr2_ok;
              drop_runt  = s_axis_tlast;
            end
            3'd3: begin
              sip_d        = {be16(s_axis_tdata, 2), be16(s_axis_tdata, 4)};
              dip_d[31:16] = be16(s_axis_tdata, 6);
              drop_runt    = s_axis_tlast;
            end
            3'd4: begin
              dip_d[15:0] = be16(s_axis_tdata, 0);
              sport_d     = be16(s_axis_tdata, 2);
              dport_d     = be16(s_axis_tdata, 4);
              ulen_d      = be16(s_axis_tdata, 6);
              drop_runt   = s_axis_tlast;
            end
            default: begin
              // Beat 5: lanes 0-1 are the UDP checksum, lanes 2-7 open the payload.
              if (s_axis_tlast && in_c <= 4'd2) begin
                drop_runt = 1'b1;
              end else begin
                udp_cnt_d  = udp_cnt_q + 32'd1;
                src_ip_d   = sip_q;
                dst_ip_d   = dip_q;
                src_port_d = sport_q;
                dst_port_d = dport_q;
                udp_len_d  = ulen_q;
                tuser_d    = ts_q;
                hold_d     = s_axis_tdata[63:16];
                beat_d     = 3'd0;
                res_d      = 3'(in_c - 4'd2);
                state_d    = s_axis_tlast ? ST_FLUSH : ST_PAYLOAD;
              end
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        ready_c = out_free;
        if (s_axis_tvalid && out_free) begin
          tdata_d  = {s_axis_tdata[15:0], hold_q};
          tvalid_d = 1'b1;
          hold_d   = s_axis_tdata[63:16];
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          if (s_axis_tlast) begin
            if (in_c <= 4'd2) begin
              tkeep_d = lo_mask(in_c + 4'd6);
              tlast_d = 1'b1;
              state_d = ST_HDR;
            end else begin
              res_d   = 3'(in_c - 4'd2);
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        // The residual beat is loaded as soon as the output register frees up.
        if (out_free) begin
          tdata_d  = {16'h0000, hold_q};
          tkeep_d  = lo_mask({1'b0, res_q});
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_DROP: begin
        ready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase

    // A protocol failure wins over a runt when the failing beat is also tlast.
    if (drop_proto) begin
      proto_cnt_d = proto_cnt_q + 32'd1;
      beat_d      = 3'd0;
      state_d     = s_axis_tlast ? ST_HDR : ST_DROP;
    end else if (drop_runt) begin
      runt_cnt_d = runt_cnt_q + 32'd1;
      beat_d     = 3'd0;
      state_d    = ST_HDR;
    end
  end

  // NOTE: non-blocking assignments so every register samples the values that
  // were settled before this edge, independent of statement order. The hold and
  // shadow registers are reset too, because all outputs must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HDR;  beat_q <= '0;   hold_q <= '0;   res_q <= '0;
      ts_q <= '0;  sip_q <= '0;  dip_q <= '0;  sport_q <= '0;  dport_q <= '0;  ulen_q <= '0;
      tdata_q <= '0;  tkeep_q <= '0;  tvalid_q <= 1'b0;  tlast_q <= 1'b0;  tuser_q <= '0;
      src_ip_q <= '0;  dst_ip_q <= '0;  src_port_q <= '0;  dst_port_q <= '0;  udp_len_q <= '0;
      udp_cnt_q <= '0;  runt_cnt_q <= '0;  proto_cnt_q <= '0;
    end else begin
      state_q <= state_d;  beat_q <= beat_d;  hold_q <= hold_d;  res_q <= res_d;
      ts_q <= ts_d;  sip_q <= sip_d;  dip_q <= dip_d;  sport_q <= sport_d;
      dport_q <= dport_d;  ulen_q <= ulen_d;
      tdata_q <= tdata_d;  tkeep_q <= tkeep_d;  tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;  tuser_q <= tuser_d;
      src_ip_q <= src_ip_d;  dst_ip_q <= dst_ip_d;  src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;  udp_len_q <= udp_len_d;
      udp_cnt_q <= udp_cnt_d;  runt_cnt_q <= runt_cnt_d;  proto_cnt_q <= proto_cnt_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0.
  assign s_axis_tready    = ready_c && !rst;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tkeep     = tkeep_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_tuser     = tuser_q;
  assign m_src_ip         = src_ip_q;
  assign m_dst_ip         = dst_ip_q;
  assign m_src_port       = src_port_q;
  assign m_dst_port       = dst_port_q;
  assign m_udp_len        = udp_len_q;
  assign udp_count        = udp_cnt_q;
  assign runt_drop_count  = runt_cnt_q;
  assign proto_drop_count = proto_cnt_q;

endmodule

// File: tb/tb_udp_header_parser.sv
// -----------------------------------------------------------------------------
// tb_udp_header_parser
//
// Self-checking bench for udp_header_parser. Frames are built as byte queues;
// a frame-level reference model decides drop/accept from the header bytes and
// slices the payload into expected output beats, which a monitor compares on
// every output handshake.
// -----------------------------------------------------------------------------
module tb_udp_header_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast;
  logic [47:0] s_tuser;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_valid, m_ready, m_last;
  logic [47:0] m_user;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, udp_len;
  logic [31:0] udp_cnt, runt_cnt, proto_cnt;

  udp_header_parser dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .m_src_ip(src_ip), .m_dst_ip(dst_ip), .m_src_port(src_port),
    .m_dst_port(dst_port), .m_udp_len(udp_len),
    .udp_count(udp_cnt), .runt_drop_count(runt_cnt), .proto_drop_count(proto_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [47:0] user;
  } exp_beat_t;

  exp_beat_t   exp_q[$];
  logic [7:0]  frm[$];

  // Reference state
  logic [31:0] x_udp, x_runt, x_proto, x_sip, x_dip;
  logic [15:0] x_sport, x_dport, x_ulen;
  logic [47:0] x_user;

  int rdy_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1, 2: random

  function automatic logic [63:0] keep_bits(input logic [7:0] k);
    logic [63:0] m;
    for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction

  // Well-formed UDP frame of len bytes (len >= 24) with random contents.
  task automatic build_udp(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
    frm[20] = 8'($urandom) & 8'hC0; frm[21] = 8'h00; frm[23] = 8'd17;
  endtask

  // Frame-level model: classify, then slice payload bytes 42.. into beats.
  task automatic model_frame(input logic [47:0] ts0, output bit ok);
    int len;
    bit bad;
    exp_beat_t e;
    len = frm.size();
    bad = ({frm[12], frm[13]} != 16'h0800) || (frm[14] != 8'h45) ||
          ((({frm[20], frm[21]}) & 16'h3FFF) != 16'h0) || (frm[23] != 8'd17);
    ok = 1'b0;
    if (bad) x_proto++;
    else if (len <= 42) x_runt++;
    else begin
      ok = 1'b1;
      x_udp++;
      x_sip   = {frm[26], frm[27], frm[28], frm[29]};
      x_dip   = {frm[30], frm[31], frm[32], frm[33]};
      x_sport = {frm[34], frm[35]};
      x_dport = {frm[36], frm[37]};
      x_ulen  = {frm[38], frm[39]};
      x_user  = ts0;
      for (int k = 42; k < len; k += 8) begin
        e.data = '0; e.keep = '0;
        for (int j = 0; j < 8; j++)
          if (k + j < len) begin e.data[8*j +: 8] = frm[k+j]; e.keep[j] = 1'b1; end
        e.last = (k + 8 >= len);
        e.user = ts0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Drives the frame in frm; returns right after presenting abort_beat.
  task automatic send_frame(input logic [47:0] ts0, input bit ok,
                            input int abort_beat, input bit gaps);
    int len, nb, waited, idx;
    len = frm.size();
    nb  = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      for (int j = 0; j < 8; j++) begin
        idx = b * 8 + j;
        s_tdata[8*j +: 8] = (idx < len) ? frm[idx] : 8'h00;
        s_tkeep[j]        = (idx < len);
      end
      s_tlast  = (b == nb - 1);
      s_tuser  = (b == 0) ? ts0 : ~ts0;
      s_tvalid = 1'b1;
      if (b == abort_beat) return;
      waited = 0;
      forever begin
        @(negedge clk);
        if (b >= 6 && ok) check("s_ready_payload", s_tready, !(m_valid && !m_ready));
        else if (b >= 1 && waited == 0) check("s_ready_hdr", s_tready, 1);
        if (s_tready) break;
        waited++;
        if (waited > 300) begin check("s_ready_timeout", s_tready, 1); break; end
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain_and_check();
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
      waited++;
      if (waited > 1000) begin check("drain_timeout", 64'(exp_q.size()), 0); break; end
    end
    check("udp_count", udp_cnt, x_udp);
    check("runt_drop_count", runt_cnt, x_runt);
    check("proto_drop_count", proto_cnt, x_proto);
    check("src_ip", src_ip, x_sip);
    check("dst_ip", dst_ip, x_dip);
    check("src_port", src_port, x_sport);
    check("dst_port", dst_port, x_dport);
    check("udp_len", udp_len, x_ulen);
    check("sideband_tuser", m_user, x_user);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [47:0] ts0, input bit gaps);
    bit ok;
    model_frame(ts0, ok);
    send_frame(ts0, ok, -1, gaps);
    drain_and_check();
  endtask

  task automatic clear_model();
    exp_q.delete();
    x_udp = '0; x_runt = '0; x_proto = '0; x_sip = '0; x_dip = '0;
    x_sport = '0; x_dport = '0; x_ulen = '0; x_user = '0;
  endtask

  // Output monitor: scoreboard on handshake, stability while stalled.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  always @(negedge clk) begin
    exp_beat_t e;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_keep", m_keep, prev_keep);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_data & keep_bits(e.keep), e.data);
          check("out_keep", m_keep, e.keep);
          check("out_last", m_last, e.last);
          check("out_tuser", m_user, e.user);
        end
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_keep  <= m_keep;
      prev_last  <= m_last;
    end
  end

  // Output-ready driver.
  initial begin
    int ph;
    ph = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin m_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len;
    logic [47:0] ts;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_udp_count", udp_cnt, 0);
    check("rst_s_ready", s_tready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", s_tready, 1);

    // Directed lengths: 60, 64, 43 (one byte), 42 (runt)
    build_udp(60); run_frame(48'h1111_2222_3333, 0);
    build_udp(64); run_frame(48'h0000_0000_0064, 0);
    build_udp(43); run_frame(48'h0000_0000_0043, 0);
    build_udp(42); run_frame(48'h0000_0000_0042, 0);

    // Protocol drops back-to-back
    build_udp(60); frm[12] = 8'h86; frm[13] = 8'hDD;
    model_frame(48'h1, ok); send_frame(48'h1, ok, -1, 0);
    build_udp(60); frm[23] = 8'd6;
    model_frame(48'h2, ok); send_frame(48'h2, ok, -1, 0);
    build_udp(60); frm[20] = frm[20] | 8'h20;
    model_frame(48'h3, ok); send_frame(48'h3, ok, -1, 0);
    drain_and_check();

    // 100-byte frame with ready pattern 1,0,0,1
    rdy_mode = 1;
    build_udp(100); run_frame(48'hBEEF_0000_0100, 0);
    rdy_mode = 0;

    // Timestamp only from beat 0; ports from bytes 34-37
    build_udp(80); run_frame(48'h0000_0000_ABCD, 0);

    // Reset during beat 7
    build_udp(80);
    model_frame(48'h77, ok);
    send_frame(48'h77, ok, 7, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_tuser", m_user, 0);
    check("midrst_src_ip", src_ip, 0);
    check("midrst_udp_count", udp_cnt, 0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    build_udp(60); run_frame(48'h0000_0000_5A5A, 0);

    // Randomized frames, errors, valid gaps and output back-pressure
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(24, 130);
      build_udp(len);
      case ($urandom_range(0, 7))
        4:       begin frm[12] = 8'h86; frm[13] = 8'hDD; end
        5:       frm[14] = 8'h46;
        6:       frm[23] = 8'd6;
        7:       if ($urandom_range(0, 1) == 1) frm[20] = frm[20] | 8'h20;
                 else frm[21] = 8'h01;
        default: ;
      endcase
      ts = {16'($urandom), $urandom};
      run_frame(ts, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
